song_autoplay_ctrl: RTL and testbench

Autoplay and lesson sequencer for the FPGA piano. Steps through a stored melody, driving the shared 4-bit note bus of the piano tone generator and the 8-bit note LEDs for a fixed time per note, with a silent gap between notes. Live keyboard input has priority over playback, so the player can take over the shared tone generator at any time. Playback pauses while the player holds a key.

---
 rtl/piano_pkg.sv | 37 +++
 rtl/song_autoplay_ctrl_if.sv | 19 +
 rtl/song_rom.sv | 44 ++++
 rtl/song_autoplay_ctrl.sv | 156 +++++++++++++++
 tb/tb_song_autoplay_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - Shared note codes, LED patterns, sequencer states and ROM field widths
package piano_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int IDX_W   = 4;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0, NOTE_C4 = 4'd1, NOTE_D = 4'd2,
                                NOTE_E = 4'd3, NOTE_F = 4'd4, NOTE_G = 4'd5,
                                NOTE_A = 4'd6, NOTE_B = 4'd7, NOTE_C5 = 4'd8;

  localparam logic [7:0] LED_NONE = 8'h00, LED_C4 = 8'h01, LED_D = 8'h02, LED_E = 8'h04,
                         LED_F = 8'h08, LED_G = 8'h10, LED_A = 8'h20, LED_B = 8'h40,
                         LED_C5 = 8'h80;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_DONE} state_e;

  function automatic logic note_valid(input logic [NOTE_W-1:0] n);
    return (n >= NOTE_C4) && (n <= NOTE_C5);
  endfunction

  function automatic logic [7:0] led_decode(input logic [NOTE_W-1:0] n);
    case (n)
      NOTE_C4: return LED_C4;
      NOTE_D:  return LED_D;
      NOTE_E:  return LED_E;
      NOTE_F:  return LED_F;
      NOTE_G:  return LED_G;
      NOTE_A:  return LED_A;
      NOTE_B:  return LED_B;
      NOTE_C5: return LED_C5;
      default: return LED_NONE;
    endcase
  endfunction

endpackage

// File: rtl/song_autoplay_ctrl_if.sv
// rtl/song_autoplay_ctrl_if.sv - Control, live-key and tone-generator signals of the autoplay sequencer
interface song_autoplay_ctrl_if;
  import piano_pkg::*;

  logic              start;
  logic              stop;
  logic              song_sel;
  logic [NOTE_W-1:0] note_in;
  logic [NOTE_W-1:0] note_out;
  logic [7:0]        Led;
  logic              busy;
  logic              done;

  modport master (output start, stop, song_sel, note_in,
                  input  note_out, Led, busy, done);
  modport slave  (input  start, stop, song_sel, note_in,
                  output note_out, Led, busy, done);

endinterface

// File: rtl/song_rom.sv
// rtl/song_rom.sv - Combinational melody store: entry {note, dur}, dur==0 marks the end of a song
module song_rom
  import piano_pkg::*;
(
  input  logic              song_sel,
  input  logic [IDX_W-1:0]  idx,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  dur
);

  localparam logic [DUR_W-1:0] BEAT1 = 3'd1, BEAT2 = 3'd2, END_MARK = 3'd0;

  logic [ENTRY_W-1:0] entry;

  always_comb begin
    entry = {NOTE_NONE, END_MARK};
    if (!song_sel) begin
      case (idx)
        4'd0, 4'd1, 4'd6, 4'd11, 4'd12: entry = {NOTE_E, BEAT1};
        4'd2, 4'd5:                     entry = {NOTE_F, BEAT1};
        4'd3, 4'd4:                     entry = {NOTE_G, BEAT1};
        4'd7, 4'd10, 4'd13:             entry = {NOTE_D, BEAT1};
        4'd8, 4'd9:                     entry = {NOTE_C4, BEAT1};
        4'd14:                          entry = {NOTE_D, BEAT2};
        default:                        entry = {NOTE_NONE, END_MARK};
      endcase
    end else begin
      case (idx)
        4'd0:    entry = {NOTE_C4, BEAT1};
        4'd1:    entry = {NOTE_D, BEAT1};
        4'd2:    entry = {NOTE_E, BEAT1};
        4'd3:    entry = {NOTE_F, BEAT1};
        4'd4:    entry = {NOTE_G, BEAT1};
        4'd5:    entry = {NOTE_A, BEAT1};
        4'd6:    entry = {NOTE_B, BEAT1};
        4'd7:    entry = {NOTE_C5, BEAT1};
        default: entry = {NOTE_NONE, END_MARK};
      endcase
    end
  end

  assign {note, dur} = entry;

endmodule

// File: rtl/song_autoplay_ctrl.sv
// rtl/song_autoplay_ctrl.sv - Melody autoplay sequencer with live-key override and pause
// Define LOOP_PLAYBACK_EN to restart the song at its end marker instead of stopping.
module song_autoplay_ctrl
  import piano_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int GAP_TICKS      = 2_500_000
) (
  input logic                 CLK,
  input logic                 RESET,
  song_autoplay_ctrl_if.slave bus
);

  localparam int BEAT_TW = $clog2(4 * TICKS_PER_BEAT);
  localparam int GAP_TW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TW      = (BEAT_TW > GAP_TW) ? BEAT_TW : GAP_TW;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              sel_q, sel_d;
  logic [NOTE_W-1:0] cur_note_q, cur_note_d;
  logic [NOTE_W-1:0] note_out_q, note_out_d;
  logic [7:0]        led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              paused, advance, first_sel;
  logic [IDX_W-1:0]  idx_next;
  logic [NOTE_W-1:0] first_note, next_note;
  logic [DUR_W-1:0]  first_dur, next_dur;
`ifdef LOOP_PLAYBACK_EN
  logic              wrap;
`endif

  function automatic logic [TW-1:0] beat_ticks(input logic [DUR_W-1:0] d);
    return TW'(int'(d) * TICKS_PER_BEAT - 1);
  endfunction

  // Before start the song is not latched yet, so entry 0 is read with the live select.
  assign first_sel = (state_q == ST_IDLE) ? bus.song_sel : sel_q;
  assign idx_next  = idx_q + IDX_W'(1);
  assign paused    = note_valid(bus.note_in);

  song_rom u_rom_first (.song_sel(first_sel), .idx('0),      .note(first_note), .dur(first_dur));
  song_rom u_rom_next  (.song_sel(sel_q),     .idx(idx_next), .note(next_note),  .dur(next_dur));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    sel_d      = sel_q;
    cur_note_d = cur_note_q;
    advance    = 1'b0;
`ifdef LOOP_PLAYBACK_EN
    wrap       = 1'b0;
`endif
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sel_d = bus.song_sel;
            idx_d = '0;
            if (first_dur == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_PLAY;
              timer_d    = beat_ticks(first_dur);
              cur_note_d = first_note;
            end
          end
        end
        ST_PLAY: begin
          if (!paused) begin
            if (timer_q != '0) begin
              timer_d = timer_q - TW'(1);
            end else if (GAP_TICKS > 0) begin
              timer_d = TW'(GAP_TICKS - 1);
              state_d = ST_GAP;
            end else begin
              advance = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (!paused) begin
            if (timer_q != '0) timer_d = timer_q - TW'(1);
            else               advance = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (advance) begin
        if (next_dur == '0) begin
`ifdef LOOP_PLAYBACK_EN
          wrap       = 1'b1;
          idx_d      = '0;
          timer_d    = beat_ticks(first_dur);
          cur_note_d = first_note;
          state_d    = ST_PLAY;
`else
          state_d    = ST_DONE;
`endif
        end else begin
          idx_d      = idx_next;
          timer_d    = beat_ticks(next_dur);
          cur_note_d = next_note;
          state_d    = ST_PLAY;
        end
      end
    end
  end

  // Live keys win over playback on the shared tone generator.
  assign note_out_d = paused ? bus.note_in : ((state_q == ST_PLAY) ? cur_note_q : NOTE_NONE);
  assign led_d      = led_decode(note_out_d);
  assign busy_d     = (state_q == ST_PLAY) || (state_q == ST_GAP);
`ifdef LOOP_PLAYBACK_EN
  assign done_d     = wrap || ((state_q == ST_DONE) && !bus.stop);
`else
  assign done_d     = (state_q == ST_DONE) && !bus.stop;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      sel_q      <= 1'b0;
      cur_note_q <= NOTE_NONE;
      note_out_q <= NOTE_NONE;
      led_q      <= LED_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      cur_note_q <= cur_note_d;
      note_out_q <= note_out_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.note_out = note_out_q;
  assign bus.Led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_song_autoplay_ctrl.sv
// tb/tb_song_autoplay_ctrl.sv - Directed and randomized checks of song_autoplay_ctrl against a segment-queue model
module tb_song_autoplay_ctrl;

  localparam int T = 4;
  localparam int G = 1;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  song_autoplay_ctrl_if bus();

  song_autoplay_ctrl #(.TICKS_PER_BEAT(T), .GAP_TICKS(G)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, cyc = 0;
  int first_cyc = -1, done_cnt = 0, last_done = 0, prev_done = 0;
  bit busy_drop = 0;

  int song0_n[16] = '{3,3,4,5,5,4,3,2,1,1,2,3,3,2,2,0};
  int song0_d[16] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,2,0};
  int song1_n[16] = '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0};
  int song1_d[16] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0};

  // Model: the song is a queue of (note, cycles) segments; gaps are note 0.
  int seg_note[$];
  int seg_left[$];
  bit m_active = 0, m_done_next = 0;
  logic m_sel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_song(input logic sl);
    seg_note.delete();
    seg_left.delete();
    for (int i = 0; i < 16; i++) begin
      int n, d;
      n = sl ? song1_n[i] : song0_n[i];
      d = sl ? song1_d[i] : song0_d[i];
      if (d == 0) break;
      seg_note.push_back(n);
      seg_left.push_back(d * T);
      if (G > 0) begin
        seg_note.push_back(0);
        seg_left.push_back(G);
      end
    end
  endtask

  task automatic model_step(input logic st, input logic sp, input logic sl, input logic [3:0] ni,
                            output logic [3:0] en, output logic [7:0] el,
                            output logic eb, output logic ed);
    bit paused, was_done;
    paused = (ni >= 1) && (ni <= 8);
    en = 4'd0;
    if (paused) en = ni;
    else if (m_active) en = 4'(seg_note[0]);
    el = (en == 4'd0) ? 8'h00 : (8'h01 << (en - 4'd1));
    eb = m_active;
    ed = m_done_next && !sp;
    was_done = m_done_next;
    m_done_next = 0;
    if (sp) begin
      m_active = 0;
      seg_note.delete();
      seg_left.delete();
    end else if (m_active) begin
      if (!paused) begin
        seg_left[0] = seg_left[0] - 1;
        if (seg_left[0] == 0) begin
          void'(seg_note.pop_front());
          void'(seg_left.pop_front());
          if (seg_note.size() == 0) begin
`ifdef LOOP_PLAYBACK_EN
            load_song(m_sel);
            ed = 1'b1;
`else
            m_active = 0;
            m_done_next = 1;
`endif
          end
        end
      end
    end else if (st && !was_done) begin
      m_sel = sl;
      load_song(sl);
      m_active = 1;
    end
  endtask

  task automatic tick(input logic st, input logic sp, input logic sl, input logic [3:0] ni);
    logic [3:0] en;
    logic [7:0] el;
    logic eb, ed;
    bus.start = st;
    bus.stop = sp;
    bus.song_sel = sl;
    bus.note_in = ni;
    model_step(st, sp, sl, ni, en, el, eb, ed);
    @(posedge CLK);
    #1;
    cyc++;
    chk("note_out", 32'(bus.note_out), 32'(en));
    chk("Led", 32'(bus.Led), 32'(el));
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("done", 32'(bus.done), 32'(ed));
    if (first_cyc < 0 && bus.note_out != 4'd0) first_cyc = cyc;
    if (first_cyc >= 0 && !bus.busy) busy_drop = 1;
    if (bus.done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
    end
  endtask

  task automatic run_quiet(input int n, input logic sl);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, sl, 4'd0);
  endtask

  task automatic clear_stats();
    first_cyc = -1;
    done_cnt = 0;
    last_done = 0;
    prev_done = 0;
    busy_drop = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.song_sel = 1'b0;
    bus.note_in = 4'd0;

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("rst_note_out", 32'(bus.note_out), 32'd0);
    chk("rst_Led", 32'(bus.Led), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    run_quiet(10, 1'b0);

`ifndef LOOP_PLAYBACK_EN
    clear_stats();
    tick(1'b1, 1'b0, 1'b1, 4'd0);
    run_quiet(50, 1'b1);
    chk("scale_done_cnt", 32'(done_cnt), 32'd1);
    chk("scale_len", 32'(last_done - first_cyc), 32'd40);

    clear_stats();
    tick(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 10 && first_cyc < 0; i++) tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("pause_c4_seen", 32'(first_cyc >= 0), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, 4'd5);
      chk("pause_key_note", 32'(bus.note_out), 32'd5);
      chk("pause_key_led", 32'(bus.Led), 32'h10);
    end
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("pause_resume_c4", 32'(bus.note_out), 32'd1);
    run_quiet(50, 1'b1);
    chk("pause_done_cnt", 32'(done_cnt), 32'd1);
    chk("pause_len", 32'(last_done - first_cyc), 32'd43);
`endif

    clear_stats();
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    run_quiet(11, 1'b0);
    chk("stop_third_note", 32'(bus.note_out), 32'd4);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("stop_note_off", 32'(bus.note_out), 32'd0);
    chk("stop_busy_off", 32'(bus.busy), 32'd0);
    run_quiet(60, 1'b0);
    chk("stop_no_done", 32'(done_cnt), 32'd0);

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 4'd0);
    chk("start_stop_idle", 32'(bus.busy), 32'd0);

`ifndef LOOP_PLAYBACK_EN
    clear_stats();
    tick(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 30; i++)
      tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 4'd0);
    run_quiet(20, 1'b1);
    chk("busy_ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("busy_ign_len", 32'(last_done - first_cyc), 32'd40);
`else
    clear_stats();
    tick(1'b1, 1'b0, 1'b1, 4'd0);
    run_quiet(130, 1'b1);
    chk("loop_done_cnt", 32'(done_cnt), 32'd3);
    chk("loop_period", 32'(last_done - prev_done), 32'd40);
    chk("loop_busy_held", 32'(busy_drop), 32'd0);
    tick(1'b0, 1'b1, 1'b1, 4'd0);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("loop_stop_busy", 32'(bus.busy), 32'd0);
`endif

    for (int ep = 0; ep < 30; ep++) begin
      int key_left;
      logic [3:0] key;
      logic sl;
      sl = 1'($urandom_range(0, 1));
      key_left = 0;
      key = 4'd0;
      tick(1'b1, 1'b0, sl, 4'd0);
      for (int n = 0; n < 160 && (m_active || m_done_next); n++) begin
        logic sp;
        if (key_left == 0) begin
          key = 4'd0;
          if (m_active && $urandom_range(0, 11) == 0) begin
            key = 4'($urandom_range(0, 15));
            key_left = $urandom_range(1, 4);
          end
        end
        if (!m_active) key = 4'd0;
        if (key_left > 0) key_left--;
        sp = (n == 150) || ($urandom_range(0, 199) == 0);
        tick(1'($urandom_range(0, 1)), sp, 1'($urandom_range(0, 1)), key);
      end
      run_quiet(3, sl);
      chk("episode_idle", 32'(bus.busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
